// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches to instruction memory, tags each
// response with its request address and buffers {pc, instruction} pairs in a small FIFO for
// the processor. Branch/jump redirects flush the FIFO and drain any responses still in flight.
module instr_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        busy
);

    // Counters must hold the value DEPTH itself; pointers only index 0..DEPTH-1.
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    typedef enum logic {
        StRun,
        StDrain
    } state_e;

    state_e state_q;

    logic [31:0]   pc_q;
    logic [CW-1:0] outstanding_q;
    logic [CW-1:0] outstanding_d;
    logic [CW-1:0] fifo_count_q;
    logic [CW-1:0] fifo_count_d;

    // Instruction FIFO (data + tag) and the per-request address queue.
    logic [31:0]   fifo_instr_mem [DEPTH];
    logic [31:0]   fifo_pc_mem    [DEPTH];
    logic [31:0]   tag_mem        [DEPTH];
    logic [PW-1:0] fifo_rd_q;
    logic [PW-1:0] fifo_wr_q;
    logic [PW-1:0] tag_rd_q;
    logic [PW-1:0] tag_wr_q;

    logic [CW:0]   inflight;
    logic          req_fire;
    logic          rsp_fire;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_target;

    // Low address bits of a redirect target are deliberately ignored.
    logic          unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    assign redirect_target = {redirect_pc[31:2], 2'b00};

    // Every buffered or in-flight word owns one FIFO slot, so the FIFO can never overflow.
    assign inflight = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
    assign imem_req = (state_q == StRun) && !redirect && (inflight < {1'b0, DEPTH_C});
    assign imem_addr = pc_q;

    assign req_fire = imem_req && imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored outright.
    assign rsp_fire = imem_rvalid && (outstanding_q != '0);
    // Responses are kept only in RUN and only when no redirect flushes the FIFO this cycle.
    assign push     = rsp_fire && (state_q == StRun) && !redirect;
    assign pop      = instr_valid && instr_ready;

    assign instr_valid = (fifo_count_q != '0);
    assign instruction = instr_valid ? fifo_instr_mem[fifo_rd_q] : '0;
    assign instr_pc    = instr_valid ? fifo_pc_mem[fifo_rd_q] : '0;
    assign busy        = (outstanding_q != '0) || (state_q == StDrain);

    // Outstanding count after this cycle's grant and response accounting.
    always_comb begin
        outstanding_d = outstanding_q;
        if (req_fire && !rsp_fire) begin
            outstanding_d = outstanding_q + CW'(1);
        end else if (!req_fire && rsp_fire) begin
            outstanding_d = outstanding_q - CW'(1);
        end
    end

    // FIFO occupancy; a redirect empties it regardless of push/pop.
    always_comb begin
        fifo_count_d = fifo_count_q;
        if (redirect) begin
            fifo_count_d = '0;
        end else if (push && !pop) begin
            fifo_count_d = fifo_count_q + CW'(1);
        end else if (!push && pop) begin
            fifo_count_d = fifo_count_q - CW'(1);
        end
    end

    // Control state: fetch FSM, pc, counters and queue pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StRun;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            fifo_count_q  <= '0;
            fifo_rd_q     <= '0;
            fifo_wr_q     <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            fifo_count_q  <= fifo_count_d;

            if (redirect) begin
                pc_q <= redirect_target;
            end else if (req_fire) begin
                pc_q <= pc_q + 32'd4;
            end

            // The tag queue tracks every in-flight request, including ones being drained.
            if (req_fire) begin
                tag_wr_q <= next_ptr(tag_wr_q);
            end
            if (rsp_fire) begin
                tag_rd_q <= next_ptr(tag_rd_q);
            end

            if (redirect) begin
                fifo_rd_q <= '0;
                fifo_wr_q <= '0;
            end else begin
                if (push) begin
                    fifo_wr_q <= next_ptr(fifo_wr_q);
                end
                if (pop) begin
                    fifo_rd_q <= next_ptr(fifo_rd_q);
                end
            end

            case (state_q)
                StRun: begin
                    if (redirect && (outstanding_d != '0)) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (outstanding_d == '0) begin
                        state_q <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counters and pointers.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem[tag_wr_q] <= pc_q;
        end
        if (push) begin
            fifo_instr_mem[fifo_wr_q] <= imem_rdata;
            fifo_pc_mem[fifo_wr_q]    <= tag_mem[tag_rd_q];
        end
    end

    a_outstanding_bound : assert property (
        @(posedge clk) disable iff (reset) outstanding_q <= DEPTH_C
    );
    a_fifo_count_bound : assert property (
        @(posedge clk) disable iff (reset) fifo_count_q <= DEPTH_C
    );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model compared every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_instr_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;

    instr_fetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic auto_rsp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Reference model: requested-but-unanswered addresses, buffered {pc, word} pairs, and a
    // count of in-flight responses that a redirect has condemned.
    logic [31:0] m_pc;
    logic [31:0] m_pend[$];
    logic [63:0] m_fifo[$];
    int          m_discard;
    logic        exp_req;
    logic [63:0] head;
    logic [31:0] rsp_addr;

    initial begin
        m_pc      = RESET_PC;
        m_discard = 0;
    end

    // Inputs are stable from just after one rising edge to the next, so the negedge both
    // checks this cycle's outputs and advances the model across the coming edge.
    always @(negedge clk) begin
        if (reset) begin
            m_pc      = RESET_PC;
            m_discard = 0;
            m_pend.delete();
            m_fifo.delete();
        end
        exp_req = (m_discard == 0) && !redirect && (m_fifo.size() + m_pend.size() < DEPTH);
        check("model imem_req", 32'(imem_req), 32'(exp_req));
        check("model imem_addr", imem_addr, m_pc);
        check("model instr_valid", 32'(instr_valid), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            head = m_fifo[0];
            check("model instr_pc", instr_pc, head[63:32]);
            check("model instruction", instruction, head[31:0]);
        end
        check("model busy", 32'(busy), 32'(m_pend.size() != 0));
        if (!reset) begin
            if (m_fifo.size() != 0 && instr_ready) m_fifo.delete(0);
            if (imem_rvalid && m_pend.size() != 0) begin
                rsp_addr = m_pend.pop_front();
                if (m_discard != 0) m_discard--;
                else if (!redirect) m_fifo.push_back({rsp_addr, imem_rdata});
            end
            if (exp_req && imem_gnt) begin
                m_pend.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
            if (redirect) begin
                m_fifo.delete();
                m_pc      = {redirect_pc[31:2], 2'b00};
                m_discard = m_pend.size();
            end
        end
    end

    // One clock; with auto_rsp the memory answers every grant on the following cycle.
    task automatic step();
        logic        fire;
        logic [31:0] a;
        @(negedge clk);
        fire = imem_req && imem_gnt;
        a    = imem_addr;
        @(posedge clk);
        #1;
        if (auto_rsp) begin
            imem_rvalid = fire;
            imem_rdata  = fire ? mk(a) : 32'h0;
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int cnt;

    initial begin
        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; auto_rsp = 1'b1;
        steps(2);
        check("reset instr_valid", 32'(instr_valid), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset instruction", instruction, 32'h0);
        check("reset instr_pc", instr_pc, 32'h0);
        check("reset imem_addr", imem_addr, 32'h0);

        // Streaming: gnt always, one-cycle memory latency, processor always ready.
        reset = 1'b0; imem_gnt = 1'b1; instr_ready = 1'b1; #1;
        check("stream first req", 32'(imem_req), 32'h1);
        check("stream first addr", imem_addr, 32'h0);
        step();
        check("stream addr 4", imem_addr, 32'h4);
        check("stream not yet valid", 32'(instr_valid), 32'h0);
        step();
        check("stream valid 2 after gnt", 32'(instr_valid), 32'h1);
        check("stream instr_pc 0", instr_pc, 32'h0);
        check("stream instruction 0", instruction, 32'hDEAD_0000);
        check("stream addr 8", imem_addr, 32'h8);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (instr_valid) cnt++;
            step();
        end
        check("stream one per cycle", 32'(cnt), 32'd8);

        // Back-pressure: processor stalls, fetch must stop at DEPTH words.
        imem_gnt = 1'b0;
        steps(4);
        redirect = 1'b1; redirect_pc = 32'h0000_1000;
        step();
        redirect = 1'b0; instr_ready = 1'b0; imem_gnt = 1'b1; #1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (imem_req && imem_gnt) cnt++;
            step();
        end
        check("stall grant count", 32'(cnt), 32'd4);
        check("stall req low", 32'(imem_req), 32'h0);
        check("stall addr", imem_addr, 32'h0000_1010);
        check("stall fifo full valid", 32'(instr_valid), 32'h1);
        check("stall not busy", 32'(busy), 32'h0);
        instr_ready = 1'b1; #1;
        check("stall req low in pop cycle", 32'(imem_req), 32'h0);
        step();
        check("req resumes after pop", 32'(imem_req), 32'h1);
        steps(6);

        // Redirect with three requests outstanding, then drain their responses.
        imem_gnt = 1'b0;
        steps(6);
        auto_rsp = 1'b0; imem_rvalid = 1'b0; imem_gnt = 1'b1;
        steps(3);
        imem_gnt = 1'b0; #1;
        check("three outstanding busy", 32'(busy), 32'h1);
        redirect = 1'b1; redirect_pc = 32'h0000_0102; #1;
        check("redirect blocks req", 32'(imem_req), 32'h0);
        step();
        redirect = 1'b0; #1;
        check("redirect pc aligned", imem_addr, 32'h0000_0100);
        check("redirect fifo empty", 32'(instr_valid), 32'h0);
        check("drain no req", 32'(imem_req), 32'h0);
        check("drain busy", 32'(busy), 32'h1);
        for (int i = 0; i < 3; i++) begin
            imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0000 + 32'(i);
            step();
        end
        imem_rvalid = 1'b0; #1;
        check("drain dropped all", 32'(instr_valid), 32'h0);
        check("drain done not busy", 32'(busy), 32'h0);
        check("drain done req", 32'(imem_req), 32'h1);
        check("drain done addr", imem_addr, 32'h0000_0100);

        // Redirect in the same cycle as a pop and a response.
        auto_rsp = 1'b1; imem_gnt = 1'b1;
        steps(6);
        check("pop-redirect head valid", 32'(instr_valid), 32'h1);
        check("pop-redirect head pc", instr_pc, 32'h0000_0110);
        redirect = 1'b1; redirect_pc = 32'h0000_2003;
        step();
        redirect = 1'b0; #1;
        check("pop-redirect fifo empty", 32'(instr_valid), 32'h0);
        check("pop-redirect not busy", 32'(busy), 32'h0);
        check("pop-redirect req", 32'(imem_req), 32'h1);
        check("pop-redirect addr", imem_addr, 32'h0000_2000);

        // pc wraps from the top of the address space.
        imem_gnt = 1'b0;
        steps(4);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0; imem_gnt = 1'b1; #1;
        check("wrap start addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap addr 0", imem_addr, 32'h0);
        step();
        check("wrap instr_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap instruction", instruction, 32'h2152_FFFC);

        // Reset with two outstanding and two buffered words.
        imem_gnt = 1'b0;
        steps(4);
        auto_rsp = 1'b0; imem_rvalid = 1'b0; instr_ready = 1'b0; imem_gnt = 1'b1;
        steps(2);
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        step();
        imem_rdata = 32'h2222_2222;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; #1;
        check("pre-reset busy", 32'(busy), 32'h1);
        check("pre-reset valid", 32'(instr_valid), 32'h1);
        reset = 1'b1; #1;
        check("async reset valid", 32'(instr_valid), 32'h0);
        check("async reset busy", 32'(busy), 32'h0);
        check("async reset instruction", instruction, 32'h0);
        check("async reset addr", imem_addr, RESET_PC);
        step();
        reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333; #1;
        check("req right after reset", 32'(imem_req), 32'h1);
        step();
        imem_rvalid = 1'b0; #1;
        check("late rvalid ignored", 32'(instr_valid), 32'h0);
        check("late rvalid not busy", 32'(busy), 32'h0);

        auto_rsp = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1;
        steps(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: prefetch FIFO entries and maximum in-flight memory requests.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-006 The block SHALL have port imem_addr, output, 32 bits: word-aligned fetch address, equal to the pc register.
REQ-007 The block SHALL have port imem_gnt, input, 1 bit: memory accepts the request this cycle.
REQ-008 The block SHALL have port imem_rvalid, input, 1 bit: read data valid; responses return in request order.
REQ-009 The block SHALL have port imem_rdata, input, 32 bits: returned instruction word.
REQ-010 The block SHALL have port instruction, output, 32 bits: FIFO head, consumed by processor.
REQ-011 The block SHALL have port instr_pc, output, 32 bits: address of the FIFO head instruction.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: FIFO head holds a valid instruction.
REQ-013 The block SHALL have port instr_ready, input, 1 bit: processor accepts the head this cycle.
REQ-014 The block SHALL have port redirect, input, 1 bit: branch/jump; restart fetch at redirect_pc.
REQ-015 The block SHALL have port redirect_pc, input, 32 bits: new fetch address; bits [1:0] ignored (forced to 0).
REQ-016 The block SHALL have port busy, output, 1 bit: high when outstanding != 0 or state == DRAIN.

Function
REQ-017 The block SHALL implement states RUN and DRAIN.
REQ-018 The block SHALL drive imem_req = (state==RUN) && !redirect && (fifo_count + outstanding < DEPTH), combinationally.
REQ-019 The block SHALL hold imem_addr stable while imem_req is high without imem_gnt.
REQ-020 On imem_req && imem_gnt, the block SHALL increment pc by 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0) and outstanding by 1.
REQ-021 On imem_rvalid in RUN, the block SHALL write {pc_tag, imem_rdata} into the FIFO and decrement outstanding; the pc_tag is the address of that request, kept in a per-request address queue.
REQ-022 Written data SHALL appear on instruction/instr_valid the cycle after the rvalid edge (no bypass).
REQ-023 instr_valid SHALL equal (fifo_count != 0); on instr_valid && instr_ready, the head SHALL be popped.
REQ-024 Simultaneous push and pop SHALL leave fifo_count unchanged; FIFO pointers wrap modulo DEPTH.
REQ-025 On redirect, the block SHALL load pc with {redirect_pc[31:2],2'b00} and clear the FIFO; a pop handshake in the same cycle completes first.
REQ-026 On redirect with outstanding != 0 after this cycle's gnt/rvalid accounting, the block SHALL enter DRAIN with discard = outstanding.
REQ-027 On redirect with outstanding == 0, the block SHALL stay in RUN and request from the new pc on the next cycle.
REQ-028 In DRAIN, the block SHALL drop each imem_rvalid, decrement outstanding, and go to RUN on the cycle outstanding reaches 0.
REQ-029 A redirect in DRAIN SHALL reload pc and remain in DRAIN.
REQ-030 An imem_rvalid with outstanding == 0 is a protocol error; the block SHALL ignore it without changing state.
REQ-031 The outstanding and fifo_count counters SHALL never exceed DEPTH.

Reset
REQ-032 While reset is high, the block SHALL asynchronously set pc=RESET_PC, state=RUN, outstanding=0, FIFO empty, instr_valid=0, busy=0, instruction=0, instr_pc=0.
REQ-033 Reset mid-operation SHALL discard all in-flight requests and FIFO contents; the first imem_req SHALL occur in the first cycle after reset deasserts.

Verification
REQ-034 Reset release, gnt always 1, rvalid one cycle after gnt, ready=1 -> imem_addr 0,4,8,...; instruction for pc 0 valid 2 cycles after its gnt; one instruction per cycle sustained.
REQ-035 ready=0 with DEPTH=4 -> exactly 4 grants; imem_req low while fifo_count+outstanding==4; req resumes the cycle after the first pop.
REQ-036 3 outstanding, redirect to 32'h0000_0102 -> pc=32'h0000_0100, FIFO empty, DRAIN drops 3 responses, next imem_addr 32'h0000_0100.
REQ-037 redirect coinciding with pop and rvalid -> popped word delivered, rvalid word dropped, FIFO empty next cycle.
REQ-038 pc=32'hFFFF_FFFC granted -> next imem_addr 32'h0000_0000; instr_pc of that word = 32'hFFFF_FFFC.
REQ-039 Reset asserted with 2 outstanding and 2 FIFO entries -> instr_valid=0 and busy=0 immediately; late rvalid after release ignored.
